// File: rtl/mc_pkg.sv
// Shared definitions for the missionaries/cannibals move checker and sequencer.
package mc_pkg;

  localparam int POP_W        = 3;
  localparam int MC_N_M       = 3;
  localparam int MC_N_C       = 3;
  localparam int MC_BOAT_CAP  = 2;

  typedef logic [POP_W-1:0] pop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } mc_state_e;

endpackage

// File: rtl/mc_bank_safe.sv
// Safety test for one bank: missionaries are safe when absent or not outnumbered.
module mc_bank_safe
  import mc_pkg::*;
(
  input  pop_t m,
  input  pop_t c,
  output logic safe
);

  assign safe = (m == '0) || (m >= c);

endmodule

// File: rtl/missionary_cannibal_move_checker.sv
// Consumes boat crossings, tracks bank populations and flags win/loss.
//
// state | meaning
// IDLE  | waiting for start, moves ignored
// PLAY  | accepting moves, one judged per valid cycle
// WON   | everyone on the right bank, terminal until reset
// LOST  | some bank has missionaries outnumbered, terminal until reset
module missionary_cannibal_move_checker
  import mc_pkg::*;
#(
  parameter int N_M      = MC_N_M,
  parameter int N_C      = MC_N_C,
  parameter int BOAT_CAP = MC_BOAT_CAP,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             move_valid,
  input  logic [2:0]       move_m,
  input  logic [2:0]       move_c,
  output logic             move_ready,
  output logic             move_accept,
  output logic             move_reject,
  output logic [2:0]       missionaries_left,
  output logic [2:0]       cannibals_left,
  output logic [2:0]       missionaries_right,
  output logic [2:0]       cannibals_right,
  output logic             boat_side,
  output logic [CNT_W-1:0] move_count,
  output logic             game_won,
  output logic             game_lost,
  output logic [1:0]       fsm_state
);

  // Boat capacity clipped to the 4-bit load sum so the compare never truncates.
  localparam logic [3:0] CAP4 = (BOAT_CAP > 15) ? 4'd15 : 4'(BOAT_CAP);
  localparam pop_t       TOT_M = pop_t'(N_M);
  localparam pop_t       TOT_C = pop_t'(N_C);

  mc_state_e        state_q, state_n;
  pop_t             m_left_q, m_left_n;
  pop_t             c_left_q, c_left_n;
  logic             side_q, side_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             acc_q, acc_n;
  logic             rej_q, rej_n;

  pop_t       m_right, c_right;
  pop_t       src_m, src_c;
  logic [3:0] load;
  logic       legal;
  pop_t       post_m_left, post_c_left;
  pop_t       post_m_right, post_c_right;
  logic       safe_left, safe_right;
  logic       fire;

  assign m_right = TOT_M - m_left_q;
  assign c_right = TOT_C - c_left_q;

  // The boat always loads from the bank it is currently moored at.
  assign src_m = side_q ? m_right : m_left_q;
  assign src_c = side_q ? c_right : c_left_q;

  assign load  = {1'b0, move_m} + {1'b0, move_c};
  assign legal = (load != 4'd0) && (load <= CAP4) &&
                 (move_m <= src_m) && (move_c <= src_c);

  assign post_m_left  = side_q ? (m_left_q + move_m) : (m_left_q - move_m);
  assign post_c_left  = side_q ? (c_left_q + move_c) : (c_left_q - move_c);
  assign post_m_right = TOT_M - post_m_left;
  assign post_c_right = TOT_C - post_c_left;

  mc_bank_safe u_safe_left (
    .m    (post_m_left),
    .c    (post_c_left),
    .safe (safe_left)
  );

  mc_bank_safe u_safe_right (
    .m    (post_m_right),
    .c    (post_c_right),
    .safe (safe_right)
  );

  assign fire = move_valid && (state_q == PLAY);

  // Next-state, bank update and pulse generation.
  always_comb begin
    state_n  = state_q;
    m_left_n = m_left_q;
    c_left_n = c_left_q;
    side_n   = side_q;
    cnt_n    = cnt_q;
    acc_n    = 1'b0;
    rej_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_n = PLAY;
      end
      PLAY: begin
        if (fire) begin
          if (legal) begin
            acc_n    = 1'b1;
            m_left_n = post_m_left;
            c_left_n = post_c_left;
            side_n   = ~side_q;
            if (cnt_q != '1) cnt_n = cnt_q + 1'b1;
            // Unsafe takes priority over completion.
            if (!(safe_left && safe_right)) begin
              state_n = LOST;
            end else if ((post_m_left == '0) && (post_c_left == '0) && !side_q) begin
              state_n = WON;
            end
          end else begin
            rej_n = 1'b1;
          end
        end
      end
      WON:  state_n = WON;
      LOST: state_n = LOST;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      m_left_q <= TOT_M;
      c_left_q <= TOT_C;
      side_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      m_left_q <= m_left_n;
      c_left_q <= c_left_n;
      side_q   <= side_n;
      cnt_q    <= cnt_n;
      acc_q    <= acc_n;
      rej_q    <= rej_n;
    end
  end

  assign move_ready         = (state_q == PLAY);
  assign move_accept        = acc_q;
  assign move_reject        = rej_q;
  assign missionaries_left  = m_left_q;
  assign cannibals_left     = c_left_q;
  assign missionaries_right = m_right;
  assign cannibals_right    = c_right;
  assign boat_side          = side_q;
  assign move_count         = cnt_q;
  assign game_won           = (state_q == WON);
  assign game_lost          = (state_q == LOST);
  assign fsm_state          = state_q;

endmodule
